// File: rtl/floo_axis_vc_receiver_if.sv
// Signal bundle between the AXI-Stream/credit link layer, the chimney flit inputs
// and the virtual-channel receiver. The slave modport is the receiver side.
interface floo_axis_vc_receiver_if #(
  parameter int unsigned NumChannels     = 2,
  parameter int unsigned FlitDataSize    = 64,
  parameter int unsigned FifoDepth       = 4,
  parameter int unsigned StreamDataBytes = (FlitDataSize + $clog2(NumChannels) + 7) / 8,
  parameter int unsigned ChanIdWidth     = (NumChannels > 1) ? $clog2(NumChannels) : 1,
  parameter int unsigned CntWidth        = $clog2(FifoDepth + 1)
);
  logic                                  axis_tvalid_i;
  logic                                  axis_tready_o;
  logic [StreamDataBytes*8-1:0]          axis_tdata_i;
  logic [NumChannels-1:0]                flit_valid_o;
  logic [NumChannels-1:0]                flit_ready_i;
  logic [NumChannels*FlitDataSize-1:0]   flit_data_o;
  logic                                  credit_valid_o;
  logic                                  credit_ready_i;
  logic [ChanIdWidth-1:0]                credit_chan_o;
  logic [CntWidth-1:0]                   credit_cnt_o;
  logic                                  error_o;

  modport slave (
    input  axis_tvalid_i, axis_tdata_i, flit_ready_i, credit_ready_i,
    output axis_tready_o, flit_valid_o, flit_data_o,
    output credit_valid_o, credit_chan_o, credit_cnt_o, error_o
  );

  modport master (
    output axis_tvalid_i, axis_tdata_i, flit_ready_i, credit_ready_i,
    input  axis_tready_o, flit_valid_o, flit_data_o,
    input  credit_valid_o, credit_chan_o, credit_cnt_o, error_o
  );
endinterface

// File: rtl/floo_axis_vc_receiver.sv
// Receive endpoint of the credit-based VC AXI-Stream link: demuxes beats into
// per-channel FIFOs and returns freed slots to the transmitter as credit messages.
module floo_axis_vc_receiver #(
  parameter int unsigned NumChannels     = 2,
  parameter int unsigned FlitDataSize    = 64,
  parameter int unsigned FifoDepth       = 4,
  parameter int unsigned StreamDataBytes = (FlitDataSize + $clog2(NumChannels) + 7) / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  floo_axis_vc_receiver_if.slave bus
);
  localparam int unsigned ChanIdWidth = (NumChannels > 1) ? $clog2(NumChannels) : 1;
  localparam int unsigned CntWidth    = $clog2(FifoDepth + 1);
  localparam int unsigned PtrWidth    = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

  logic [FlitDataSize-1:0] r_mem     [NumChannels][FifoDepth];
  logic [PtrWidth-1:0]     r_rd_ptr  [NumChannels];
  logic [PtrWidth-1:0]     r_wr_ptr  [NumChannels];
  logic [CntWidth-1:0]     r_count   [NumChannels];
  logic [CntWidth-1:0]     r_pending [NumChannels];
  logic                    r_cred_valid;
  logic [ChanIdWidth-1:0]  r_cred_chan;
  logic [CntWidth-1:0]     r_cred_cnt;
  logic [ChanIdWidth-1:0]  r_rr_ptr;
  logic                    r_error;

  logic [31:0]             w_chan;
  logic                    w_beat;
  logic                    w_bad;
  logic                    w_overflow;
  logic [NumChannels-1:0]  w_push;
  logic [NumChannels-1:0]  w_pop;
  logic [NumChannels-1:0]  w_nonempty;
  logic                    w_loadable;
  logic                    w_grant_vld;
  logic [ChanIdWidth-1:0]  w_grant;
  logic [31:0]             w_idx;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(FifoDepth - 1)) ? {PtrWidth{1'b0}} : p + PtrWidth'(1);
  endfunction

  // A single channel carries no id bits on the stream, so its id is always 0.
  if (NumChannels > 1) begin : g_chan
    assign w_chan = 32'(bus.axis_tdata_i[FlitDataSize +: ChanIdWidth]);
  end else begin : g_chan_single
    assign w_chan = 32'd0;
  end

  assign bus.axis_tready_o = rst_ni;
  assign w_beat     = bus.axis_tvalid_i & rst_ni;
  assign w_bad      = (w_chan >= 32'(NumChannels));
  assign w_loadable = ~r_cred_valid | bus.credit_ready_i;

  // Demux and pop decode; a full FIFO still takes a push when it pops this cycle.
  always_comb begin
    w_push     = {NumChannels{1'b0}};
    w_pop      = {NumChannels{1'b0}};
    w_nonempty = {NumChannels{1'b0}};
    w_overflow = 1'b0;
    for (int c = 0; c < NumChannels; c++) begin
      w_nonempty[c] = (r_count[c] != {CntWidth{1'b0}});
      w_pop[c]      = w_nonempty[c] & bus.flit_ready_i[c];
      if (w_beat && !w_bad && (w_chan == 32'(c))) begin
        if ((r_count[c] != CntWidth'(FifoDepth)) || w_pop[c]) begin
          w_push[c] = 1'b1;
        end else begin
          w_overflow = 1'b1;
        end
      end else begin
        w_push[c] = 1'b0;
      end
    end
  end

  // Round-robin pick among channels with pending credit, starting at r_rr_ptr.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = {ChanIdWidth{1'b0}};
    w_idx       = 32'd0;
    for (int k = 0; k < NumChannels; k++) begin
      w_idx = 32'(r_rr_ptr) + 32'(k);
      w_idx = (w_idx >= 32'(NumChannels)) ? w_idx - 32'(NumChannels) : w_idx;
      if (!w_grant_vld && (r_pending[w_idx[ChanIdWidth-1:0]] != {CntWidth{1'b0}})) begin
        w_grant_vld = 1'b1;
        w_grant     = w_idx[ChanIdWidth-1:0];
      end else begin
        w_grant_vld = w_grant_vld;
      end
    end
  end

  // FIFO storage array, no reset needed.
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NumChannels; c++) begin
      if (w_push[c]) begin
        r_mem[c][r_wr_ptr[c]] <= bus.axis_tdata_i[FlitDataSize-1:0];
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int c = 0; c < NumChannels; c++) begin
        r_rd_ptr[c] <= {PtrWidth{1'b0}};
        r_wr_ptr[c] <= {PtrWidth{1'b0}};
        r_count[c]  <= {CntWidth{1'b0}};
      end
    end else begin
      for (int c = 0; c < NumChannels; c++) begin
        if (w_push[c]) r_wr_ptr[c] <= ptr_inc(r_wr_ptr[c]);
        if (w_pop[c])  r_rd_ptr[c] <= ptr_inc(r_rd_ptr[c]);
        r_count[c] <= r_count[c] + CntWidth'(w_push[c]) - CntWidth'(w_pop[c]);
      end
    end
  end

  // Credit accounting and message register; a pop on the granted channel in the
  // load cycle seeds its pending count instead of being lost.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int c = 0; c < NumChannels; c++) r_pending[c] <= {CntWidth{1'b0}};
      r_cred_valid <= 1'b0;
      r_cred_chan  <= {ChanIdWidth{1'b0}};
      r_cred_cnt   <= {CntWidth{1'b0}};
      r_rr_ptr     <= {ChanIdWidth{1'b0}};
      r_error      <= 1'b0;
    end else begin
      for (int c = 0; c < NumChannels; c++) begin
        r_pending[c] <= r_pending[c] + CntWidth'(w_pop[c]);
      end
      if (w_loadable && w_grant_vld) begin
        r_cred_valid       <= 1'b1;
        r_cred_chan        <= w_grant;
        r_cred_cnt         <= r_pending[w_grant];
        r_pending[w_grant] <= CntWidth'(w_pop[w_grant]);
        r_rr_ptr           <= (w_grant == ChanIdWidth'(NumChannels - 1)) ?
                              {ChanIdWidth{1'b0}} : w_grant + ChanIdWidth'(1);
      end else if (w_loadable) begin
        r_cred_valid <= 1'b0;
      end
      if (w_overflow || (w_beat && w_bad)) r_error <= 1'b1;
    end
  end

  // Head-of-FIFO presentation per channel.
  always_comb begin
    bus.flit_data_o = {(NumChannels*FlitDataSize){1'b0}};
    for (int c = 0; c < NumChannels; c++) begin
      bus.flit_data_o[c*FlitDataSize +: FlitDataSize] = r_mem[c][r_rd_ptr[c]];
    end
  end

  assign bus.flit_valid_o   = w_nonempty;
  assign bus.credit_valid_o = r_cred_valid;
  assign bus.credit_chan_o  = r_cred_chan;
  assign bus.credit_cnt_o   = r_cred_cnt;
  assign bus.error_o        = r_error;
endmodule

// File: tb/tb_floo_axis_vc_receiver.sv
// Directed bench: 2-channel/64-bit instance for the main flows, 3-channel/8-bit
// instance for the out-of-range channel id.
module tb_floo_axis_vc_receiver;
  localparam int unsigned AFlit = 64;
  localparam int unsigned BFlit = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  floo_axis_vc_receiver_if #(.NumChannels(2), .FlitDataSize(AFlit), .FifoDepth(4)) a_if ();
  floo_axis_vc_receiver_if #(.NumChannels(3), .FlitDataSize(BFlit), .FifoDepth(4)) b_if ();

  floo_axis_vc_receiver #(.NumChannels(2), .FlitDataSize(AFlit), .FifoDepth(4)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .bus(a_if.slave));
  floo_axis_vc_receiver #(.NumChannels(3), .FlitDataSize(BFlit), .FifoDepth(4)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .bus(b_if.slave));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_beat(input logic ch, input logic [63:0] d);
    a_if.axis_tvalid_i = 1'b1;
    a_if.axis_tdata_i  = {7'h00, ch, d};
  endtask

  task automatic a_cred(input string tag, input logic v, input logic ch, input logic [2:0] cnt);
    chk({tag, "_cv"}, 128'(a_if.credit_valid_o), 128'(v));
    if (v) begin
      chk({tag, "_ch"}, 128'(a_if.credit_chan_o), 128'(ch));
      chk({tag, "_cn"}, 128'(a_if.credit_cnt_o), 128'(cnt));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_if.axis_tvalid_i = 1'b0; a_if.axis_tdata_i = 72'h0;
    a_if.flit_ready_i = 2'b00; a_if.credit_ready_i = 1'b0;
    b_if.axis_tvalid_i = 1'b0; b_if.axis_tdata_i = 16'h0;
    b_if.flit_ready_i = 3'b000; b_if.credit_ready_i = 1'b0;

    // Reset state
    tick();
    chk("rst_tready", 128'(a_if.axis_tready_o), 128'd0);
    chk("rst_fvalid", 128'(a_if.flit_valid_o), 128'd0);
    chk("rst_cvalid", 128'(a_if.credit_valid_o), 128'd0);
    chk("rst_cchan", 128'(a_if.credit_chan_o), 128'd0);
    chk("rst_ccnt", 128'(a_if.credit_cnt_o), 128'd0);
    chk("rst_err", 128'(a_if.error_o), 128'd0);
    chk("rst_b_fvalid", 128'(b_if.flit_valid_o), 128'd0);
    rst_n = 1'b1;
    #1;
    chk("run_tready", 128'(a_if.axis_tready_o), 128'd1);

    // Single flit on ch1, then its credit two cycles after the pop
    a_beat(1'b1, 64'hA5);
    tick();
    a_if.axis_tvalid_i = 1'b0;
    chk("single_valid", 128'(a_if.flit_valid_o), 128'b10);
    chk("single_data", 128'(a_if.flit_data_o[127:64]), 128'hA5);
    a_if.flit_ready_i = 2'b10;
    tick();
    a_if.flit_ready_i = 2'b00;
    chk("single_popped", 128'(a_if.flit_valid_o), 128'd0);
    a_cred("single_c1", 1'b0, 1'b0, 3'd0);
    tick();
    a_cred("single_c2", 1'b1, 1'b1, 3'd1);
    a_if.credit_ready_i = 1'b1;
    tick();
    a_cred("single_c3", 1'b0, 1'b0, 3'd0);
    a_if.credit_ready_i = 1'b0;

    // Fill ch0, push+pop while full, overflow, drain in order
    for (int i = 0; i < 4; i++) begin
      a_beat(1'b0, 64'(32'h10 + i));
      tick();
    end
    chk("fill_err", 128'(a_if.error_o), 128'd0);
    chk("fill_valid", 128'(a_if.flit_valid_o), 128'b01);
    chk("fill_head", 128'(a_if.flit_data_o[63:0]), 128'h10);
    a_beat(1'b0, 64'h14);
    a_if.flit_ready_i = 2'b01;
    tick();
    chk("fullpop_err", 128'(a_if.error_o), 128'd0);
    chk("fullpop_head", 128'(a_if.flit_data_o[63:0]), 128'h11);
    a_if.flit_ready_i = 2'b00;
    a_beat(1'b0, 64'h15);
    tick();
    a_if.axis_tvalid_i = 1'b0;
    chk("ovf_err", 128'(a_if.error_o), 128'd1);
    chk("ovf_head", 128'(a_if.flit_data_o[63:0]), 128'h11);
    a_cred("ovf_c", 1'b1, 1'b0, 3'd1);
    a_if.flit_ready_i = 2'b01;
    tick(); chk("drain_h12", 128'(a_if.flit_data_o[63:0]), 128'h12);
    tick(); chk("drain_h13", 128'(a_if.flit_data_o[63:0]), 128'h13);
    tick(); chk("drain_h14", 128'(a_if.flit_data_o[63:0]), 128'h14);
    tick();
    a_if.flit_ready_i = 2'b00;
    chk("drain_empty", 128'(a_if.flit_valid_o), 128'd0);
    a_cred("drain_hold", 1'b1, 1'b0, 3'd1);
    a_if.credit_ready_i = 1'b1;
    tick(); a_cred("drain_c4", 1'b1, 1'b0, 3'd4);
    tick(); a_cred("drain_cidle", 1'b0, 1'b0, 3'd0);

    // Credit aggregation under credit backpressure
    a_if.credit_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_beat(1'b0, 64'(32'h20 + i));
      tick();
    end
    a_if.axis_tvalid_i = 1'b0;
    chk("agg_head", 128'(a_if.flit_data_o[63:0]), 128'h20);
    a_if.flit_ready_i = 2'b01;
    tick(); tick(); tick();
    a_if.flit_ready_i = 2'b00;
    a_cred("agg_first", 1'b1, 1'b0, 3'd1);
    tick();
    a_cred("agg_stable", 1'b1, 1'b0, 3'd1);
    a_if.credit_ready_i = 1'b1;
    tick(); a_cred("agg_second", 1'b1, 1'b0, 3'd2);
    tick(); a_cred("agg_idle", 1'b0, 1'b0, 3'd0);

    // Round-robin with both channels popping every cycle (pointer now at ch1)
    for (int i = 0; i < 8; i++) begin
      a_beat(1'(i), 64'(32'h30 + i));
      tick();
    end
    a_if.axis_tvalid_i = 1'b0;
    chk("rr_fvalid", 128'(a_if.flit_valid_o), 128'b11);
    chk("rr_head1", 128'(a_if.flit_data_o[127:64]), 128'h31);
    a_if.flit_ready_i = 2'b11;
    tick(); a_cred("rr_q1", 1'b0, 1'b0, 3'd0);
    tick(); a_cred("rr_q2", 1'b1, 1'b1, 3'd1);
    tick(); a_cred("rr_q3", 1'b1, 1'b0, 3'd2);
    tick(); a_cred("rr_q4", 1'b1, 1'b1, 3'd2);
    a_if.flit_ready_i = 2'b00;
    chk("rr_drained", 128'(a_if.flit_valid_o), 128'd0);
    tick(); a_cred("rr_q5", 1'b1, 1'b0, 3'd2);
    tick(); a_cred("rr_q6", 1'b1, 1'b1, 3'd1);
    tick(); a_cred("rr_q7", 1'b0, 1'b0, 3'd0);

    // Reset mid-stream with flits buffered and a credit pending
    a_if.credit_ready_i = 1'b0;
    a_beat(1'b0, 64'h40); tick();
    a_beat(1'b0, 64'h41); tick();
    a_beat(1'b1, 64'h42); tick();
    a_if.axis_tvalid_i = 1'b0;
    a_if.flit_ready_i = 2'b10;
    tick();
    a_if.flit_ready_i = 2'b00;
    tick();
    a_cred("pre_rst", 1'b1, 1'b1, 3'd1);
    chk("pre_rst_err", 128'(a_if.error_o), 128'd1);
    chk("pre_rst_fv", 128'(a_if.flit_valid_o), 128'b01);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_fv", 128'(a_if.flit_valid_o), 128'd0);
    chk("mid_rst_cv", 128'(a_if.credit_valid_o), 128'd0);
    chk("mid_rst_err", 128'(a_if.error_o), 128'd0);
    chk("mid_rst_tready", 128'(a_if.axis_tready_o), 128'd0);
    rst_n = 1'b1;
    a_if.flit_ready_i = 2'b11;
    a_if.credit_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_fv", 128'(a_if.flit_valid_o), 128'd0);
      chk("post_rst_cv", 128'(a_if.credit_valid_o), 128'd0);
    end
    a_if.flit_ready_i = 2'b00;
    a_beat(1'b0, 64'h55);
    tick();
    a_if.axis_tvalid_i = 1'b0;
    chk("post_rst_beat_v", 128'(a_if.flit_valid_o), 128'b01);
    chk("post_rst_beat_d", 128'(a_if.flit_data_o[63:0]), 128'h55);

    // Out-of-range channel id on the 3-channel instance
    b_if.axis_tvalid_i = 1'b1;
    b_if.axis_tdata_i  = 16'h0377;
    tick();
    chk("bad_err", 128'(b_if.error_o), 128'd1);
    chk("bad_fv", 128'(b_if.flit_valid_o), 128'd0);
    b_if.axis_tdata_i  = 16'h0299;
    tick();
    b_if.axis_tvalid_i = 1'b0;
    chk("ch2_fv", 128'(b_if.flit_valid_o), 128'b100);
    chk("ch2_data", 128'(b_if.flit_data_o[23:16]), 128'h99);
    chk("ch2_err_sticky", 128'(b_if.error_o), 128'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
